// File: rtl/npn4_pkg.sv
// Shared types and the lexicographic permutation table for the 4-input NPN canonicalizer.
`default_nettype none

package npn4_pkg;

  typedef logic [15:0] tt16_t;

  localparam int NUM_PERMS = 24;

  typedef struct packed {
    logic [4:0] perm;
    logic [3:0] neg;
    logic       oneg;
  } npn_xform_t;

  // Entry k packs {p[3], p[2], p[1], p[0]}, 2 bits each; rows in lexicographic order of p.
  localparam logic [7:0] PERM_TABLE [NUM_PERMS] = '{
    {2'd3, 2'd2, 2'd1, 2'd0}, {2'd2, 2'd3, 2'd1, 2'd0}, {2'd3, 2'd1, 2'd2, 2'd0},
    {2'd1, 2'd3, 2'd2, 2'd0}, {2'd2, 2'd1, 2'd3, 2'd0}, {2'd1, 2'd2, 2'd3, 2'd0},
    {2'd3, 2'd2, 2'd0, 2'd1}, {2'd2, 2'd3, 2'd0, 2'd1}, {2'd3, 2'd0, 2'd2, 2'd1},
    {2'd0, 2'd3, 2'd2, 2'd1}, {2'd2, 2'd0, 2'd3, 2'd1}, {2'd0, 2'd2, 2'd3, 2'd1},
    {2'd3, 2'd1, 2'd0, 2'd2}, {2'd1, 2'd3, 2'd0, 2'd2}, {2'd3, 2'd0, 2'd1, 2'd2},
    {2'd0, 2'd3, 2'd1, 2'd2}, {2'd1, 2'd0, 2'd3, 2'd2}, {2'd0, 2'd1, 2'd3, 2'd2},
    {2'd2, 2'd1, 2'd0, 2'd3}, {2'd1, 2'd2, 2'd0, 2'd3}, {2'd2, 2'd0, 2'd1, 2'd3},
    {2'd0, 2'd2, 2'd1, 2'd3}, {2'd1, 2'd0, 2'd2, 2'd3}, {2'd0, 2'd1, 2'd2, 2'd3}
  };

endpackage : npn4_pkg

`default_nettype wire

// File: rtl/npn4_apply.sv
// Combinational NPN transform: g(x) = f(z), z_j = x_{p[j]} ^ n_j (output phase o = 0).
`default_nettype none

module npn4_apply
  import npn4_pkg::*;
(
  input  tt16_t      tt_in,
  input  logic [4:0] perm,
  input  logic [3:0] neg,
  output tt16_t      tt_out
);

  logic [7:0] entry;

  assign entry = PERM_TABLE[perm];

  always_comb begin
    logic [3:0] x;
    logic [3:0] z;
    tt_out = '0;
    x      = '0;
    z      = '0;
    for (int i = 0; i < 16; i++) begin
      x = 4'(i);
      for (int j = 0; j < 4; j++) begin
        z[j] = x[entry[2*j +: 2]] ^ neg[j];
      end
      tt_out[i] = tt_in[z];
    end
  end

endmodule : npn4_apply

`default_nettype wire

// File: rtl/npn4_canonicalizer.sv
// Sequential NPN canonicalizer: scans all 768 transforms, LANES input phases per cycle.
// Optional NPN_EARLY_EXIT_EN: leave SCAN as soon as the running minimum reaches 16'h0000.
`default_nettype none

module npn4_canonicalizer
  import npn4_pkg::*;
#(
  parameter int LANES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_tt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_tt,
  output logic [4:0]  out_perm,
  output logic [3:0]  out_neg,
  output logic        out_oneg
);

  localparam int GRP_W = (LANES >= 16) ? 1 : $clog2(16 / LANES);
  localparam logic [GRP_W-1:0] LAST_GRP = GRP_W'(16 / LANES - 1);
  localparam logic [4:0] LAST_PERM = 5'(NUM_PERMS - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state, state_next;
  tt16_t            tt_reg, best_tt, cand_tt;
  npn_xform_t       best_x, cand_x;
  logic [4:0]       perm_cnt;
  logic [GRP_W-1:0] grp_cnt;
  logic             last_step, scan_done;

  tt16_t      lane_tt  [LANES];
  logic [3:0] lane_neg [LANES];

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign lane_neg[l] = 4'(32'(grp_cnt) * LANES + l);
    npn4_apply u_apply (
      .tt_in  (tt_reg),
      .perm   (perm_cnt),
      .neg    (lane_neg[l]),
      .tt_out (lane_tt[l])
    );
  end

  // Walk candidates in enumeration order with strict less-than so the earliest transform wins ties.
  always_comb begin
    tt16_t trial;
    cand_tt = best_tt;
    cand_x  = best_x;
    trial   = '0;
    for (int l = 0; l < LANES; l++) begin
      for (int o = 0; o < 2; o++) begin
        trial = (o == 1) ? ~lane_tt[l] : lane_tt[l];
        if (trial < cand_tt) begin
          cand_tt     = trial;
          cand_x.perm = perm_cnt;
          cand_x.neg  = lane_neg[l];
          cand_x.oneg = (o == 1);
        end
      end
    end
  end

  assign last_step = (perm_cnt == LAST_PERM) && (grp_cnt == LAST_GRP);

`ifdef NPN_EARLY_EXIT_EN
  assign scan_done = last_step || (cand_tt == '0);
`else
  assign scan_done = last_step;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (in_valid)  state_next = ST_SCAN;
      ST_SCAN: if (scan_done) state_next = ST_DONE;
      ST_DONE: if (out_ready) state_next = ST_IDLE;
      default:                state_next = ST_IDLE;
    endcase
  end

  // Gating with rst_n keeps in_ready low while reset is held even though state sits in IDLE.
  always_comb begin
    in_ready  = rst_n && (state == ST_IDLE);
    out_valid = (state == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tt_reg   <= '0;
      best_tt  <= '0;
      best_x   <= '0;
      perm_cnt <= '0;
      grp_cnt  <= '0;
      out_tt   <= '0;
      out_perm <= '0;
      out_neg  <= '0;
      out_oneg <= 1'b0;
    end else if (state == ST_IDLE) begin
      if (in_valid) begin
        tt_reg   <= in_tt;
        best_tt  <= 16'hFFFF;
        best_x   <= '0;
        perm_cnt <= '0;
        grp_cnt  <= '0;
      end
    end else if (state == ST_SCAN) begin
      best_tt <= cand_tt;
      best_x  <= cand_x;
      if (grp_cnt == LAST_GRP) begin
        grp_cnt  <= '0;
        perm_cnt <= perm_cnt + 5'd1;
      end else begin
        grp_cnt <= grp_cnt + GRP_W'(1);
      end
      if (scan_done) begin
        out_tt   <= cand_tt;
        out_perm <= cand_x.perm;
        out_neg  <= cand_x.neg;
        out_oneg <= cand_x.oneg;
      end
    end
  end

endmodule : npn4_canonicalizer

`default_nettype wire

// File: tb/tb_npn4_canonicalizer.sv
// Self-checking bench: three instances (LANES 1/4/16), directed table, reset abort, random vs software minimiser.
`default_nettype none

module tb_npn4_canonicalizer;

`ifdef NPN_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  typedef struct {
    int          k;
    logic [15:0] tt;
    logic [4:0]  perm;
    logic [3:0]  neg;
    logic        oneg;
    int          lat;
  } exp_t;

  typedef struct {
    int          k;
    logic [15:0] in_tt;
    logic [15:0] e_tt;
    logic [4:0]  e_perm;
    logic [3:0]  e_neg;
    logic        e_oneg;
    int          hold;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid  [3];
  logic        in_ready  [3];
  logic [15:0] in_tt     [3];
  logic        out_valid [3];
  logic        out_ready [3];
  logic [15:0] out_tt    [3];
  logic [4:0]  out_perm  [3];
  logic [3:0]  out_neg   [3];
  logic        out_oneg  [3];

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    localparam int L = (k == 0) ? 1 : (k == 1) ? 4 : 16;
    npn4_canonicalizer #(.LANES(L)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[k]),
      .in_ready  (in_ready[k]),
      .in_tt     (in_tt[k]),
      .out_valid (out_valid[k]),
      .out_ready (out_ready[k]),
      .out_tt    (out_tt[k]),
      .out_perm  (out_perm[k]),
      .out_neg   (out_neg[k]),
      .out_oneg  (out_oneg[k])
    );
  end

  function automatic int lanes_of(input int k);
    return (k == 0) ? 1 : (k == 1) ? 4 : 16;
  endfunction

  function automatic int exp_lat(input int k, input logic [15:0] canon);
    return (EARLY && canon == 16'h0000) ? 1 : 384 / lanes_of(k);
  endfunction

  // Exhaustive reference: permutations generated lexicographically, then n ascending, then o.
  function automatic exp_t model(input int k, input logic [15:0] f);
    int          perms[24][4];
    int          cnt;
    logic [15:0] g;
    exp_t        e;
    cnt = 0;
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++)
        for (int c = 0; c < 4; c++)
          if (b != a && c != a && c != b) begin
            perms[cnt][0] = a;
            perms[cnt][1] = b;
            perms[cnt][2] = c;
            perms[cnt][3] = 6 - a - b - c;
            cnt++;
          end
    e.k = k; e.tt = 16'hFFFF; e.perm = '0; e.neg = '0; e.oneg = 1'b0;
    for (int p = 0; p < 24; p++)
      for (int n = 0; n < 16; n++)
        for (int o = 0; o < 2; o++) begin
          for (int x = 0; x < 16; x++) begin
            int z;
            z = 0;
            for (int j = 0; j < 4; j++)
              z = z | ((((x >> perms[p][j]) & 1) ^ ((n >> j) & 1)) << j);
            g[x] = f[z] ^ o[0];
          end
          if (g < e.tt) begin
            e.tt = g; e.perm = 5'(p); e.neg = 4'(n); e.oneg = o[0];
          end
        end
    e.lat = exp_lat(k, e.tt);
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Entered and left at posedge+1; a following call drives in the very next cycle.
  task automatic do_txn(input exp_t e, input logic [15:0] f, input int hold);
    int   k, w, lat;
    exp_t got;
    k = e.k;
    w = 0;
    while (!in_ready[k] && w < 20) begin
      @(posedge clk); #1; w++;
    end
    if (!in_ready[k]) begin
      checks++; errors++;
      $display("FAIL accept_timeout k%0d: in_ready stuck at 0, required 1", k);
      return;
    end
    in_tt[k] = f;
    in_valid[k] = 1'b1;
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid[k] = 1'b0;
    in_tt[k] = 16'($urandom);
    lat = 0;
    while (!out_valid[k] && lat < 1000) begin
      @(posedge clk); #1; lat++;
    end
    got = sb.pop_front();
    if (!out_valid[k]) begin
      checks++; errors++;
      $display("FAIL out_timeout k%0d in=%h: out_valid 0 after %0d cycles, required 1", k, f, lat);
      return;
    end
    chk($sformatf("out_tt k%0d in=%h", k, f), 32'(out_tt[k]), 32'(got.tt));
    chk($sformatf("out_perm k%0d in=%h", k, f), 32'(out_perm[k]), 32'(got.perm));
    chk($sformatf("out_neg k%0d in=%h", k, f), 32'(out_neg[k]), 32'(got.neg));
    chk($sformatf("out_oneg k%0d in=%h", k, f), 32'(out_oneg[k]), 32'(got.oneg));
    chk($sformatf("latency k%0d in=%h", k, f), 32'(lat), 32'(got.lat));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold out_valid", 32'(out_valid[k]), 32'd1);
      chk("hold out_tt", 32'(out_tt[k]), 32'(got.tt));
      chk("hold in_ready", 32'(in_ready[k]), 32'd0);
    end
    out_ready[k] = 1'b1;
    @(posedge clk); #1;
    out_ready[k] = 1'b0;
    chk($sformatf("in_ready after handshake k%0d", k), 32'(in_ready[k]), 32'd1);
    chk($sformatf("out_valid after handshake k%0d", k), 32'(out_valid[k]), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    exp_t e;
    logic [15:0] f;

    vecs[0] = '{k: 0, in_tt: 16'h8000, e_tt: 16'h0001, e_perm: 5'd0,  e_neg: 4'hF, e_oneg: 1'b0, hold: 50};
    vecs[1] = '{k: 0, in_tt: 16'hFFFF, e_tt: 16'h0000, e_perm: 5'd0,  e_neg: 4'h0, e_oneg: 1'b1, hold: 0};
    vecs[2] = '{k: 0, in_tt: 16'hAAAA, e_tt: 16'h00FF, e_perm: 5'd18, e_neg: 4'h0, e_oneg: 1'b1, hold: 0};
    vecs[3] = '{k: 1, in_tt: 16'hAAAA, e_tt: 16'h00FF, e_perm: 5'd18, e_neg: 4'h0, e_oneg: 1'b1, hold: 0};
    vecs[4] = '{k: 1, in_tt: 16'h0000, e_tt: 16'h0000, e_perm: 5'd0,  e_neg: 4'h0, e_oneg: 1'b0, hold: 0};
    vecs[5] = '{k: 1, in_tt: 16'h8000, e_tt: 16'h0001, e_perm: 5'd0,  e_neg: 4'hF, e_oneg: 1'b0, hold: 3};
    vecs[6] = '{k: 2, in_tt: 16'h6996, e_tt: 16'h6996, e_perm: 5'd0,  e_neg: 4'h0, e_oneg: 1'b0, hold: 0};
    vecs[7] = '{k: 2, in_tt: 16'hFFFE, e_tt: 16'h0001, e_perm: 5'd0,  e_neg: 4'h0, e_oneg: 1'b1, hold: 0};

    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid[k] = 1'b0; in_tt[k] = '0; out_ready[k] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset in_ready k%0d", k), 32'(in_ready[k]), 32'd0);
      chk($sformatf("reset out_valid k%0d", k), 32'(out_valid[k]), 32'd0);
      chk($sformatf("reset out_tt k%0d", k), 32'(out_tt[k]), 32'd0);
      chk($sformatf("reset xform k%0d", k), {22'd0, out_perm[k], out_neg[k], out_oneg[k]}, 32'd0);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++)
      chk($sformatf("post-reset in_ready k%0d", k), 32'(in_ready[k]), 32'd1);

    for (int i = 0; i < 8; i++) begin
      e.k = vecs[i].k; e.tt = vecs[i].e_tt; e.perm = vecs[i].e_perm;
      e.neg = vecs[i].e_neg; e.oneg = vecs[i].e_oneg;
      e.lat = exp_lat(vecs[i].k, vecs[i].e_tt);
      do_txn(e, vecs[i].in_tt, vecs[i].hold);
    end

    // Abort mid-scan: instance 0 still shows 00FF/perm 18 from its last result.
    in_tt[0] = 16'h1234;
    in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("abort out_valid k%0d", k), 32'(out_valid[k]), 32'd0);
      chk($sformatf("abort out_tt k%0d", k), 32'(out_tt[k]), 32'd0);
      chk($sformatf("abort xform k%0d", k), {22'd0, out_perm[k], out_neg[k], out_oneg[k]}, 32'd0);
      chk($sformatf("abort in_ready k%0d", k), 32'(in_ready[k]), 32'd0);
    end
    @(negedge clk) rst_n = 1'b1;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      if (out_valid[0]) begin
        checks++; errors++;
        $display("FAIL stale output after abort: out_valid 1 at cycle %0d, required 0", c);
        break;
      end
    end
    checks++;
    do_txn(model(0, 16'h1234), 16'h1234, 0);

    for (int i = 0; i < 1000; i++) begin
      f = 16'($urandom);
      do_txn(model(2, f), f, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_npn4_canonicalizer

`default_nettype wire

// File: doc/npn4_canonicalizer.md
Name: npn4_canonicalizer

Overview:
- Sequential front-end stage that sits upstream of the exact 4-input NPN circuit library.
- Takes an arbitrary 4-input Boolean function as a 16-bit truth table.
- Scans all 768 NPN transforms and returns the numerically smallest equivalent truth table (the class representative used to select an exact circuit), plus the transform that produced it.
- The downstream consumer uses the transform to rewire the selected circuit's inputs and output.

Parameters:
- LANES, 1, input-negation phases evaluated per cycle; legal values 1, 2, 4, 8, 16. Scan length is 384/LANES cycles.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_tt is valid
- in_ready  output  1  block can accept a function
- in_tt  input  16  truth table; bit index = x0 + 2*x1 + 4*x2 + 8*x3
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_tt  output  16  canonical truth table
- out_perm  output  5  permutation index 0..23
- out_neg  output  4  input negation mask n3..n0
- out_oneg  output  1  output negation

Behaviour:
- Reset and synchronicity: one clock; reset is asynchronous and active-low, on rst_n. All state clears asynchronously.
- Reset values: in_ready=0 during reset, 1 from the first cycle after deassertion. out_valid=0, out_tt=0, out_perm=0, out_neg=0, out_oneg=0.
- Transform definition: g(x) = o XOR f(z), with z_j = x_{p[j]} XOR n_j.
- Permutation table: p is listed lexicographically over the 24 permutations of (0,1,2,3). Index 0 = (0,1,2,3), index 23 = (3,2,1,0).
- Enumeration order: perm index major, then n ascending 0..15, then o = 0 before o = 1.
- Tie-break: best is updated only on strict less-than, so the earliest transform in enumeration order wins. With LANES > 1, the in-cycle reduction prefers the lower n; result is identical for every LANES value.
- FSM states:
  - IDLE: in_ready=1. On in_valid, latch in_tt; best := 16'hFFFF, best transform := 0; go to SCAN.
  - SCAN: each cycle evaluates LANES consecutive n values for the current perm, both o values each. Counter (perm, n-group) advances and wraps n into perm. After the group with perm = 23 and the last n, go to DONE.
  - DONE: out_valid=1, outputs stable. Return to IDLE on out_ready.
- Latency and throughput: in_valid handshake, then exactly 384/LANES SCAN cycles, then out_valid. in_ready is low in SCAN and DONE, so no new input is accepted until the output handshake completes. Accepting a new input is possible in the cycle after that handshake.
- Backpressure: out_ready low holds DONE indefinitely with all outputs unchanged.
- out_valid/out_tt are registered, with no combinational path from in_* to out_*.
- Reset asserted mid-SCAN or in DONE: the in-flight function is discarded; nothing is emitted.
- in_valid while in_ready=0: ignored; the sender must hold its data.

Optional Feature:
- Macro: NPN_EARLY_EXIT_EN.
- Defined: if best becomes 16'h0000 during SCAN, go to DONE at the end of that cycle. Constant functions finish in 1 SCAN cycle.
- Not defined: the full 384/LANES scan always runs.
- Reported transform is identical either way, because 0 can only be found first at its earliest occurrence.

Decomposition:
- Package npn4_pkg holds:
  - the 24-entry permutation constant table (2 bits per position);
  - typedef npn_xform_t {perm[4:0], neg[3:0], oneg};
  - constant NUM_PERMS=24;
  - typedef tt16_t.
- Sub-module npn4_apply: combinational; (tt16, perm index, neg) -> transformed tt16 for o = 0, with o = 1 as its complement. LANES instances.

Test Plan:
- in_tt=16'h8000 (AND4) -> out_tt=16'h0001, perm=0, neg=4'hF, oneg=0, out_valid exactly 384 cycles after accept with LANES=1.
- in_tt=16'hAAAA (x0) -> out_tt=16'h00FF, perm=18 (3,0,1,2), neg=4'h0, oneg=1. Repeat with LANES=4 for identical result in 96 cycles.
- in_tt=16'hFFFF -> out_tt=16'h0000, perm=0, neg=0, oneg=1. Latency 384 without the macro, 1 SCAN cycle with NPN_EARLY_EXIT_EN.
- Random in_tt (1000 vectors) -> compared against a software exhaustive NPN minimiser using the same enumeration order, including the transform fields.
- Hold out_ready=0 for 50 cycles in DONE -> outputs stable, in_ready=0. Then back-to-back inputs, each accepted the cycle after the output handshake.
- Assert rst_n low at SCAN cycle 100 -> all outputs 0 immediately. After release, a new function completes normally with no stale result.
